// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared constants for the seven-segment scanner
package seg_scan_pkg;

  localparam int NDIG = 4;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Active-low {g,f,e,d,c,b,a} codes for hex digits 0..F.
  localparam logic [6:0] SEG7_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational hex nibble to active-low seven-segment decoder
module hex_to_seg7
  import seg_scan_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  assign o_seg = SEG7_LUT[i_hex];

endmodule

// File: rtl/seg_scan_display.sv
// rtl/seg_scan_display.sv - 4-digit multiplexed common-anode display scanner with frame snapshot
// Optional leading-zero suppression: SEG_SCAN_LEADING_ZERO_BLANK_EN
module seg_scan_display
  import seg_scan_pkg::*;
#(
  parameter int DIV_W = 17
) (
  input  logic        CP,
  input  logic        CR,
  input  logic [15:0] hex_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_in,
  output logic [3:0]  AN,
  output logic [7:0]  SEGMENT,
  output logic        frame_tick
);

  logic [DIV_W-1:0]     r_presc;
  logic [1:0]           r_idx;
  logic [4*NDIG-1:0]    r_hex_sh;
  logic [NDIG-1:0]      r_dp_sh;
  logic [NDIG-1:0]      r_blank_sh;

  logic                 w_tick;
  logic                 w_snap;
  logic [3:0]           w_nib;
  logic [6:0]           w_seg;
  logic [NDIG-1:0]      w_blank;

  assign w_tick = &r_presc;
  assign w_snap = w_tick && (r_idx == 2'd3);
  assign w_nib  = r_hex_sh[{r_idx, 2'b00} +: 4];

`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
  logic w_z3, w_z32, w_z321;
  assign w_z3    = (r_hex_sh[15:12] == 4'h0);
  assign w_z32   = w_z3  && (r_hex_sh[11:8] == 4'h0);
  assign w_z321  = w_z32 && (r_hex_sh[7:4]  == 4'h0);
  // A lit decimal point keeps its digit visible even when it is a leading zero.
  assign w_blank = r_blank_sh | {w_z3   & ~r_dp_sh[3],
                                 w_z32  & ~r_dp_sh[2],
                                 w_z321 & ~r_dp_sh[1],
                                 1'b0};
`else
  assign w_blank = r_blank_sh;
`endif

  hex_to_seg7 u_dec (
    .i_hex (w_nib),
    .o_seg (w_seg)
  );

  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      r_presc <= '0;
      r_idx   <= 2'd0;
    end else begin
      r_presc <= r_presc + DIV_W'(1);
      if (w_tick) r_idx <= r_idx + 2'd1;
    end
  end

  // Shadow loads only at the end of digit3's dwell so a rippling count never tears a frame.
  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      r_hex_sh   <= '0;
      r_dp_sh    <= '0;
      r_blank_sh <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= w_snap;
      if (w_snap) begin
        r_hex_sh   <= hex_in;
        r_dp_sh    <= dp_in;
        r_blank_sh <= blank_in;
      end
    end
  end

  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      AN      <= AN_OFF;
      SEGMENT <= SEG_OFF;
    end else begin
      AN <= ~(4'b0001 << r_idx);
      if (w_blank[r_idx]) SEGMENT <= SEG_OFF;
      else                SEGMENT <= {~r_dp_sh[r_idx], w_seg};
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// tb/tb_seg_scan_display.sv - scoreboard bench for seg_scan_display at DIV_W=2
module tb_seg_scan_display;

  logic        CP = 1'b0;
  logic        CR = 1'b1;
  logic [15:0] hex_in = 16'h0000;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  blank_in = 4'h0;
  logic [3:0]  AN;
  logic [7:0]  SEGMENT;
  logic        frame_tick;

  seg_scan_display #(.DIV_W(2)) dut (
    .CP         (CP),
    .CR         (CR),
    .hex_in     (hex_in),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .AN         (AN),
    .SEGMENT    (SEGMENT),
    .frame_tick (frame_tick)
  );

  always #5 CP = ~CP;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] seg;
    logic       ft;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          m_k = 0;
  logic [15:0] m_hex = 16'h0;
  logic [3:0]  m_dp = 4'h0;
  logic [3:0]  m_blank = 4'h0;
  logic [6:0]  m_lut [16];

  initial begin
    m_lut = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_seg(input int d);
    logic [3:0] nib;
    logic       blk;
    nib = m_hex[d*4 +: 4];
    blk = m_blank[d];
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    if (d == 3) blk = blk | ((m_hex[15:12] == 0) && !m_dp[3]);
    if (d == 2) blk = blk | ((m_hex[15:8] == 0) && !m_dp[2]);
    if (d == 1) blk = blk | ((m_hex[15:4] == 0) && !m_dp[1]);
`endif
    return blk ? 8'hFF : {~m_dp[d], m_lut[nib]};
  endfunction

  // Reference: output after edge k shows digit ((k-1)/4)%4; snapshot taken at every 16th edge.
  always @(posedge CP) begin
    if (!CR) begin
      exp_t e;
      int   d;
      m_k++;
      d = ((m_k - 1) / 4) % 4;
      e.an  = ~(4'b0001 << d);
      e.seg = exp_seg(d);
      e.ft  = (m_k % 16 == 0);
      sb_q.push_back(e);
      if (m_k % 16 == 0) begin
        m_hex   = hex_in;
        m_dp    = dp_in;
        m_blank = blank_in;
      end
    end
  end

  always @(negedge CP) begin
    if (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("sb_an", AN, e.an);
      chk("sb_seg", SEGMENT, e.seg);
      chk("sb_ft", frame_tick, e.ft);
    end
  end

  task automatic wait_digit(input int d);
    logic [3:0] want;
    bit         hit;
    want = ~(4'b0001 << d);
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge CP);
      if (AN === want) hit = 1;
    end
    if (!hit) chk("digit_timeout", AN, want);
  endtask

  task automatic wait_frame();
    bit hit;
    hit = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge CP);
      if (frame_tick === 1'b1) hit = 1;
    end
    if (!hit) chk("frame_timeout", frame_tick, 1);
  endtask

  task automatic do_reset_mid();
    @(posedge CP);
    #2;
    CR = 1'b1;
    sb_q.delete();
    m_k = 0;
    m_hex = 16'h0;
    m_dp = 4'h0;
    m_blank = 4'h0;
    #1;
    chk("rst_an", AN, 4'hF);
    chk("rst_seg", SEGMENT, 8'hFF);
    chk("rst_ft", frame_tick, 0);
    repeat (3) @(posedge CP);
    @(negedge CP);
    CR = 1'b0;
  endtask

  initial begin
    logic [3:0] an_steps [4];
    an_steps = '{4'hE, 4'hD, 4'hB, 4'h7};
    hex_in = 16'h1234;
    repeat (2) @(negedge CP);
    chk("init_an", AN, 4'hF);
    chk("init_seg", SEGMENT, 8'hFF);
    chk("init_ft", frame_tick, 0);
    CR = 1'b0;

    @(negedge CP);
    chk("first_an", AN, 4'hE);
    chk("first_seg", SEGMENT, 8'hC0);
    wait_digit(1); chk("f1_d1", SEGMENT, 8'hC0);
    wait_digit(2); chk("f1_d2", SEGMENT, 8'hC0);
    wait_digit(3); chk("f1_d3", SEGMENT, 8'hC0);

    wait_frame();
    @(negedge CP);
    chk("ft_pulse", frame_tick, 0);
    wait_digit(0); chk("f2_d0", SEGMENT, 8'h99);
    wait_digit(1); chk("f2_d1", SEGMENT, 8'hB0);
    hex_in = 16'hABCD;
    wait_digit(2); chk("tear_d2", SEGMENT, 8'hA4);
    wait_digit(3); chk("tear_d3", SEGMENT, 8'hF9);

    wait_frame();
    @(negedge CP);
    chk("ft_pulse2", frame_tick, 0);
    wait_digit(0); chk("f3_d0", SEGMENT, 8'hA1);
    wait_digit(1); chk("f3_d1", SEGMENT, 8'hC6);
    wait_digit(2); chk("f3_d2", SEGMENT, 8'h83);
    wait_digit(3); chk("f3_d3", SEGMENT, 8'h88);
    dp_in = 4'b0010;
    blank_in = 4'b1000;

    wait_frame();
    wait_digit(1); chk("dp_d1", SEGMENT, 8'h46);
    wait_digit(3);
    chk("blank_an", AN, 4'h7);
    chk("blank_seg", SEGMENT, 8'hFF);

    wait_digit(1);
    do_reset_mid();
    for (int i = 0; i < 16; i++) begin
      @(negedge CP);
      if (i % 4 == 0) chk("step_an", AN, an_steps[i / 4]);
    end

    hex_in = 16'h0005;
    dp_in = 4'h0;
    blank_in = 4'h0;
    wait_frame();
`ifdef SEG_SCAN_LEADING_ZERO_BLANK_EN
    wait_digit(0); chk("lz_d0", SEGMENT, 8'h92);
    wait_digit(1); chk("lz_d1", SEGMENT, 8'hFF);
    wait_digit(2); chk("lz_d2", SEGMENT, 8'hFF);
    wait_digit(3); chk("lz_d3", SEGMENT, 8'hFF);
    hex_in = 16'h0000;
    wait_frame();
    wait_digit(0); chk("lz_zero_d0", SEGMENT, 8'hC0);
    hex_in = 16'h0005;
    dp_in = 4'b0100;
    wait_frame();
    wait_digit(1); chk("lzdp_d1", SEGMENT, 8'hFF);
    wait_digit(2); chk("lzdp_d2", SEGMENT, 8'h40);
    wait_digit(3); chk("lzdp_d3", SEGMENT, 8'hFF);
`else
    wait_digit(0); chk("nz_d0", SEGMENT, 8'h92);
    wait_digit(1); chk("nz_d1", SEGMENT, 8'hC0);
    wait_digit(2); chk("nz_d2", SEGMENT, 8'hC0);
    wait_digit(3); chk("nz_d3", SEGMENT, 8'hC0);
`endif

    repeat (4) @(negedge CP);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
